overlap_add_datapath: RTL
=========================

Name: overlap_add_datapath

Overview:
- Downstream of the overlap controller in the MPEG-2 AAC decoder.
- Consumes sample pairs: the previous window's second half on pcm_0 and the current window's first half on pcm_1, plus the sequence position.
- Computes the overlap-add with signed saturation and buffers the results in a small sample FIFO.
- Emits one 16-bit PCM sample per cycle toward the output interface, with valid/ready flow control and frame-boundary signalling.

Parameters:
- WORD_LENGTH, 16, sample width in bits.
- HALF_WINDOW_SIZE, 512, output samples per frame; power of two, at least 2.
- FIFO_DEPTH, 4, sample FIFO entries; power of two, at least 2.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  input pair beat valid.
- in_ready  output  1  block can accept a beat this cycle.
- pcm_0  input  2*WORD_LENGTH  previous-window pair; [2W-1:W] = sample n, [W-1:0] = sample n+1; signed two's complement.
- pcm_1  input  2*WORD_LENGTH  current-window pair; same packing.
- seq_pos  input  2  2'b00 middle, 2'b01 first, 2'b10 last, 2'b11 reserved.
- pcm_out  output  WORD_LENGTH  output sample, signed.
- out_valid  output  1  pcm_out valid.
- out_ready  input  1  downstream accepts pcm_out.
- frame_done  output  1  one-cycle pulse on the pop of the last sample of a frame.
- sat_flag  output  1  sticky flag: a saturation has occurred.
- clr_sat  input  1  clears sat_flag.
- seq_err  output  1  one-cycle pulse when a reserved seq_pos beat is accepted.

Behaviour:
- Reset (synchronous, rst high at the clock edge):
  - FIFO emptied, sample counter = 0.
  - in_ready = 1, out_valid = 0, pcm_out = 0.
  - frame_done = 0, sat_flag = 0, seq_err = 0.
  - rst has priority over every other event; an in-flight beat or a pending output is discarded.
- Accept: a beat is accepted when in_valid && in_ready at the rising edge.
  - in_ready = (count <= FIFO_DEPTH-2), combinational from the registered count only.
  - in_ready has no combinational path from in_valid or out_ready.
- Arithmetic, per sample lane, when the accepted seq_pos is:
  - 00: a+b, sign-extended to WORD_LENGTH+1 bits, then saturated to [-2^(W-1), 2^(W-1)-1].
  - 01: b only (previous half treated as zero).
  - 10: a only (tail flush).
  - 11: nothing written; seq_err pulses on the next cycle.
  - a = pcm_0 lane, b = pcm_1 lane.
- Saturation: sets sat_flag on the next edge. If clr_sat and a new saturation occur in the same cycle, set wins. clr_sat with no saturation clears the flag.
- FIFO write: on acceptance, sample n is written, then sample n+1, both at the same edge, occupying two consecutive entries.
- Latency: a beat accepted at edge k gives out_valid = 1 after edge k, with pcm_out = sample n. Sample n+1 follows on the next pop.
- Output handshake:
  - out_valid = (count != 0); pcm_out = FIFO head (registered storage).
  - Pop occurs when out_valid && out_ready.
  - pcm_out must hold stable while out_valid && !out_ready.
- Simultaneous push and pop: count += 1. Push alone: count += 2. Pop alone: count -= 1. Read/write pointers wrap modulo FIFO_DEPTH.
- Frame counter:
  - Increments on each pop.
  - When a pop occurs at count value HALF_WINDOW_SIZE-1: the counter wraps to 0 and frame_done = 1 in the following cycle, else 0.
  - Reserved beats do not advance the counter.
- No overflow is possible by construction. An assertion checks count never exceeds FIFO_DEPTH and never underflows.
- Bubbles on in_valid or out_ready are legal at any cycle.

Test Plan:
- Reset mid-stream: 3 samples in FIFO, assert rst one cycle -> next cycle out_valid=0, in_ready=1, sat_flag=0; counter restarts (frame_done after exactly 512 further pops).
- Middle add: seq_pos=00, pcm_0={16'h0100,16'hFFFF}, pcm_1={16'h0020,16'h0001}, out_ready=1 -> pcm_out 16'h0120 then 16'h0000, sat_flag stays 0.
- Saturation: seq_pos=00, pcm_0={16'h7FFF,16'h8000}, pcm_1={16'h0001,16'hFFFF} -> outputs 16'h7FFF, 16'h8000, sat_flag=1. Pulse clr_sat -> 0.
- First/last/reserved: seq_pos=01 with pcm_0={16'h1234,16'h1234}, pcm_1={16'h0005,16'h0006} -> 0005, 0006. seq_pos=10 with the same pairs -> 1234, 1234. seq_pos=11 -> no output, seq_err one pulse.
- Backpressure: out_ready=0 with in_valid=1 continuous -> exactly 2 beats accepted (count=4), in_ready=0, pcm_out stable. Release out_ready -> 4 samples in order, no loss or duplication.
- Frame boundary: 256 middle beats with out_ready=1 -> frame_done pulses once, on the cycle after the 512th pop; 256 further beats -> second pulse after pop 1024.

Source files
------------

// File: rtl/overlap_add_datapath.sv
// Overlap-add back end: sums previous/current half-window sample pairs with signed
// saturation, queues them in a small FIFO and streams one PCM sample per cycle.
module overlap_add_datapath #(
    parameter int WORD_LENGTH      = 16,
    parameter int HALF_WINDOW_SIZE = 512,
    parameter int FIFO_DEPTH       = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [2*WORD_LENGTH-1:0] pcm_0,
    input  logic [2*WORD_LENGTH-1:0] pcm_1,
    input  logic [1:0]               seq_pos,
    output logic [WORD_LENGTH-1:0]   pcm_out,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     frame_done,
    output logic                     sat_flag,
    input  logic                     clr_sat,
    output logic                     seq_err
);
    localparam int W  = WORD_LENGTH;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int FW = $clog2(HALF_WINDOW_SIZE);

    localparam logic [1:0] SEQ_MID   = 2'b00;
    localparam logic [1:0] SEQ_FIRST = 2'b01;
    localparam logic [1:0] SEQ_LAST  = 2'b10;
    localparam logic [1:0] SEQ_RSVD  = 2'b11;

    localparam logic [W-1:0]  SAT_MAX     = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0]  SAT_MIN     = {1'b1, {(W-1){1'b0}}};
    localparam logic [CW-1:0] READY_LIMIT = CW'(FIFO_DEPTH - 2);
    localparam logic [CW-1:0] DEPTH_MAX   = CW'(FIFO_DEPTH);
    localparam logic [FW-1:0] FRAME_LAST  = FW'(HALF_WINDOW_SIZE - 1);

    logic [W-1:0]      fifoMem [FIFO_DEPTH];
    logic [PW-1:0]     wrPtrReg, wrPtrNext;
    logic [PW-1:0]     rdPtrReg, rdPtrNext;
    logic [PW-1:0]     wrPtrInc;
    logic [CW-1:0]     countReg, countNext;
    logic [FW-1:0]     frameCntReg, frameCntNext;
    logic              frameDoneReg, frameDoneNext;
    logic              satFlagReg, satFlagNext;
    logic              seqErrReg, seqErrNext;

    logic [1:0][W-1:0] laneRes;
    logic [1:0]        laneSat;
    logic              accept;
    logic              push;
    logic              pop;
    logic              anySat;

    // Lane 0 is sample n (upper half of each pair), lane 1 is sample n+1.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : gLane
            logic signed [W-1:0] laneA;
            logic signed [W-1:0] laneB;
            logic signed [W:0]   laneSum;
            logic                laneOvf;

            assign laneA   = pcm_0[(2-gi)*W-1 -: W];
            assign laneB   = pcm_1[(2-gi)*W-1 -: W];
            assign laneSum = {laneA[W-1], laneA} + {laneB[W-1], laneB};
            // Overflow iff the extra sign bit disagrees with the W-bit sign.
            assign laneOvf = laneSum[W] ^ laneSum[W-1];

            assign laneSat[gi] = (seq_pos == SEQ_MID) && laneOvf;
            assign laneRes[gi] = (seq_pos == SEQ_FIRST) ? laneB :
                                 (seq_pos == SEQ_LAST)  ? laneA :
                                 laneOvf ? (laneSum[W] ? SAT_MIN : SAT_MAX) :
                                 laneSum[W-1:0];
        end
    endgenerate

    assign in_ready  = (countReg <= READY_LIMIT);
    assign out_valid = (countReg != '0);
    assign accept    = in_valid && in_ready;
    assign push      = accept && (seq_pos != SEQ_RSVD);
    assign pop       = out_valid && out_ready;
    assign anySat    = push && (|laneSat);
    assign wrPtrInc  = wrPtrReg + PW'(1);

    // Head entry cannot be overwritten while occupied, so pcm_out holds under backpressure.
    assign pcm_out    = out_valid ? fifoMem[rdPtrReg] : '0;
    assign frame_done = frameDoneReg;
    assign sat_flag   = satFlagReg;
    assign seq_err    = seqErrReg;

    always_comb begin
        countNext     = countReg;
        wrPtrNext     = wrPtrReg;
        rdPtrNext     = rdPtrReg;
        frameCntNext  = frameCntReg;
        frameDoneNext = 1'b0;
        satFlagNext   = satFlagReg;
        seqErrNext    = accept && (seq_pos == SEQ_RSVD);

        case ({push, pop})
            2'b10:   countNext = countReg + CW'(2);
            2'b11:   countNext = countReg + CW'(1);
            2'b01:   countNext = countReg - CW'(1);
            default: countNext = countReg;
        endcase

        if (push) begin
            wrPtrNext = wrPtrReg + PW'(2);
        end

        if (pop) begin
            rdPtrNext     = rdPtrReg + PW'(1);
            frameDoneNext = (frameCntReg == FRAME_LAST);
            frameCntNext  = (frameCntReg == FRAME_LAST) ? '0 : frameCntReg + FW'(1);
        end

        // A fresh saturation beats a simultaneous clear.
        if (anySat) begin
            satFlagNext = 1'b1;
        end else if (clr_sat) begin
            satFlagNext = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            countReg     <= '0;
            wrPtrReg     <= '0;
            rdPtrReg     <= '0;
            frameCntReg  <= '0;
            frameDoneReg <= 1'b0;
            satFlagReg   <= 1'b0;
            seqErrReg    <= 1'b0;
        end else begin
            countReg     <= countNext;
            wrPtrReg     <= wrPtrNext;
            rdPtrReg     <= rdPtrNext;
            frameCntReg  <= frameCntNext;
            frameDoneReg <= frameDoneNext;
            satFlagReg   <= satFlagNext;
            seqErrReg    <= seqErrNext;
        end
    end

    // Storage carries no reset; out_valid gates anything stale.
    always_ff @(posedge clk) begin
        if (push) begin
            fifoMem[wrPtrReg] <= laneRes[0];
            fifoMem[wrPtrInc] <= laneRes[1];
        end
    end

    // count is unsigned, so an underflow would also show up as a value above the depth.
    assert property (@(posedge clk) disable iff (rst) countReg <= DEPTH_MAX);

endmodule
